// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state type and default width for the gcd client
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} gcd_client_state_t;
  localparam int GCD_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/gcd_client_if.sv
// gcd_client_if: request stream, gcd core launch/completion and response stream of one client
interface gcd_client_if import gcd_pkg::*; #(parameter int WIDTH = GCD_DEFAULT_WIDTH);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] req_a_i;
  logic [WIDTH-1:0] req_b_i;
  logic             core_valid_o;
  logic [WIDTH-1:0] core_a_o;
  logic [WIDTH-1:0] core_b_o;
  logic             core_valid_i;
  logic [WIDTH-1:0] core_gcd_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_a_o;
  logic [WIDTH-1:0] rsp_b_o;
  logic [WIDTH-1:0] rsp_gcd_o;
  logic             rsp_timeout_o;
  logic             fault_o;
  modport master (
    input  req_valid_i, req_a_i, req_b_i, core_valid_i, core_gcd_i, rsp_ready_i,
    output req_ready_o, core_valid_o, core_a_o, core_b_o,
           rsp_valid_o, rsp_a_o, rsp_b_o, rsp_gcd_o, rsp_timeout_o, fault_o
  );
  modport slave (
    output req_valid_i, req_a_i, req_b_i, core_valid_i, core_gcd_i, rsp_ready_i,
    input  req_ready_o, core_valid_o, core_a_o, core_b_o,
           rsp_valid_o, rsp_a_o, rsp_b_o, rsp_gcd_o, rsp_timeout_o, fault_o
  );
endinterface

// File: rtl/gcd_timeout_ctr.sv
// gcd_timeout_ctr: saturating wait counter flagging the last allowed cycle before a hang
module gcd_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == W'(TIMEOUT_CYCLES - 1);
  // count up while enabled, holding at the terminal value
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk_i) cnt_q <= reset_i ? '0 : cnt_d;
endmodule

// File: rtl/gcd_client.sv
// gcd_client: launches operand pairs into one gcd core and returns {a, b, gcd, timeout}
module gcd_client import gcd_pkg::*; #(
  parameter int WIDTH          = GCD_DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic          clk_i,
  input logic          reset_i,
  gcd_client_if.master bus
);
  gcd_client_state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic to_q, to_d, fault_q, fault_d, ready_q, ready_d, core_valid_q;
  logic rise, expired;
  assign rise = bus.core_valid_i & ~core_valid_q;
  gcd_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (state_q == LAUNCH),
    .enable  (state_q == WAIT && !rise),
    .expired (expired)
  );
  // next state, operand latch and response capture
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    to_d    = to_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (bus.req_valid_i && ready_q) begin
        state_d = LAUNCH;
        a_d     = bus.req_a_i;
        b_d     = bus.req_b_i;
      end
      LAUNCH: state_d = WAIT;
      WAIT: if (rise) begin
        state_d = HOLD;
        gcd_d   = bus.core_gcd_i;
        to_d    = 1'b0;
      end else if (expired) begin
        state_d = HOLD;
        gcd_d   = '0;
        to_d    = 1'b1;
        fault_d = 1'b1;
      end
      HOLD: state_d = bus.rsp_ready_i ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE && !fault_d;
  end
  // state registers; core_valid_q tracks the core level every cycle for edge detection
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      gcd_q        <= '0;
      to_q         <= 1'b0;
      fault_q      <= 1'b0;
      ready_q      <= 1'b0;
      core_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      gcd_q        <= gcd_d;
      to_q         <= to_d;
      fault_q      <= fault_d;
      ready_q      <= ready_d;
      core_valid_q <= bus.core_valid_i;
    end
  end
  assign bus.req_ready_o   = ready_q;
  assign bus.core_valid_o  = state_q == LAUNCH;
  assign bus.core_a_o      = state_q == LAUNCH ? a_q : '0;
  assign bus.core_b_o      = state_q == LAUNCH ? b_q : '0;
  assign bus.rsp_valid_o   = state_q == HOLD;
  assign bus.rsp_a_o       = a_q;
  assign bus.rsp_b_o       = b_q;
  assign bus.rsp_gcd_o     = gcd_q;
  assign bus.rsp_timeout_o = to_q;
  assign bus.fault_o       = fault_q;
endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: scoreboard bench for gcd_client driving a behavioural gcd core model
module tb_gcd_client;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  gcd_client_if #(.WIDTH(8)) ifc();
  gcd_client #(.WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (ifc)
  );
  int checks = 0;
  int errors = 0;
  logic [24:0] exp_q[$];
  logic [24:0] exp_e;
  int mode = 0;
  logic st_v = 1'b0;
  logic [7:0] st_g = 8'd0;
  int core_cnt = 0;
  logic [7:0] pa = 8'd0;
  logic [7:0] pb = 8'd0;
  logic [7:0] sv[10] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd12, 8'd36, 8'd100, 8'd128, 8'd200, 8'd254};
  int n1, n2;
  logic [44:0] all_out;
  assign all_out = {ifc.req_ready_o, ifc.core_valid_o, ifc.core_a_o, ifc.core_b_o, ifc.rsp_valid_o,
                    ifc.rsp_a_o, ifc.rsp_b_o, ifc.rsp_gcd_o, ifc.rsp_timeout_o, ifc.fault_o};

  function automatic logic [7:0] ref_gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=bound expired required=event", name);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (!ifc.core_valid_o && n < 100) begin step; n++; end
    if (n >= 100) fail("wait_pulse");
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!ifc.rsp_valid_o && n < 100) begin step; n++; end
    if (n >= 100) fail("wait_rsp");
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] g, input logic to);
    int n;
    n = 0;
    exp_q.push_back({a, b, g, to});
    step;
    ifc.req_valid_i = 1'b1;
    ifc.req_a_i = a;
    ifc.req_b_i = b;
    while (!ifc.req_ready_o && n < 200) begin step; n++; end
    if (n >= 200) fail("req_accept");
    step;
    ifc.req_valid_i = 1'b0;
    ifc.req_a_i = 8'd0;
    ifc.req_b_i = 8'd0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin step; n++; end
    if (n >= 300) fail("drain");
  endtask

  task automatic do_reset(input string name);
    step;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk(name, all_out, 0);
    reset = 1'b0;
  endtask

  // behavioural gcd core: drops valid on a start pulse, raises it with the result a few cycles later
  initial begin
    ifc.core_valid_i = 1'b0;
    ifc.core_gcd_i = 8'd0;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        ifc.core_valid_i = 1'b0;
        ifc.core_gcd_i = 8'd0;
        core_cnt = 0;
      end else if (mode == 1) ifc.core_valid_i = 1'b0;
      else if (mode == 2) begin
        ifc.core_valid_i = st_v;
        ifc.core_gcd_i = st_g;
      end else if (ifc.core_valid_o) begin
        ifc.core_valid_i = 1'b0;
        pa = ifc.core_a_o;
        pb = ifc.core_b_o;
        core_cnt = 1 + int'(pa % 8'd3);
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          ifc.core_gcd_i = ref_gcd(pa, pb);
          ifc.core_valid_i = 1'b1;
        end
      end
    end
  end

  // response monitor: every accepted response is compared with the oldest expectation
  always @(negedge clk) begin
    if (ifc.rsp_valid_o && ifc.rsp_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual=%0h required=none",
                 {ifc.rsp_a_o, ifc.rsp_b_o, ifc.rsp_gcd_o, ifc.rsp_timeout_o});
      end else begin
        exp_e = exp_q.pop_front();
        chk("rsp", {ifc.rsp_a_o, ifc.rsp_b_o, ifc.rsp_gcd_o, ifc.rsp_timeout_o}, exp_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    ifc.req_valid_i = 1'b0;
    ifc.req_a_i = 8'd0;
    ifc.req_b_i = 8'd0;
    ifc.rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_out, 0);
    reset = 1'b0;
    step;
    chk("ready_after_reset", ifc.req_ready_o, 1);
    // T1 basic
    fork
      send(8'd48, 8'd18, 8'd6, 1'b0);
      begin
        wait_pulse(n1);
        chk("t1_core_ab", {ifc.core_a_o, ifc.core_b_o}, {8'd48, 8'd18});
        chk("t1_ready_low", ifc.req_ready_o, 0);
        step;
        chk("t1_pulse_one_cycle", {ifc.core_valid_o, ifc.core_a_o, ifc.core_b_o}, 0);
        wait_rsp(n2);
        chk("t1_latency", n2, 1);
      end
    join
    drain;
    // T2 backpressure with a queued request
    ifc.rsp_ready_i = 1'b0;
    fork
      begin
        send(8'd60, 8'd84, 8'd12, 1'b0);
        send(8'd17, 8'd23, 8'd1, 1'b0);
      end
      begin
        wait_rsp(n1);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("t2_hold", {ifc.rsp_valid_o, ifc.rsp_a_o, ifc.rsp_b_o, ifc.rsp_gcd_o, ifc.req_ready_o},
              {1'b1, 8'd60, 8'd84, 8'd12, 1'b0});
          step;
        end
        ifc.rsp_ready_i = 1'b1;
      end
    join
    drain;
    // T3 zero operands, full-range corner and a sweep
    send(8'd0, 8'd5, 8'd5, 1'b0);
    send(8'd0, 8'd0, 8'd0, 1'b0);
    send(8'd255, 8'd255, 8'd255, 1'b0);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        send(sv[i], sv[j], ref_gcd(sv[i], sv[j]), 1'b0);
    drain;
    // T4 hung core
    mode = 1;
    fork
      send(8'd10, 8'd4, 8'd0, 1'b1);
      begin
        wait_pulse(n1);
        wait_rsp(n2);
        chk("t4_wait_cycles", n2, 17);
      end
    join
    drain;
    step;
    chk("t4_fault_parked", {ifc.fault_o, ifc.req_ready_o}, 2'b10);
    mode = 2;
    st_v = 1'b0;
    ifc.req_valid_i = 1'b1;
    ifc.req_a_i = 8'd3;
    ifc.req_b_i = 8'd9;
    step;
    step;
    st_v = 1'b1;
    st_g = 8'd5;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("t4_late_edge_ignored", {ifc.fault_o, ifc.req_ready_o, ifc.rsp_valid_o, ifc.core_valid_o}, 4'b1000);
    end
    ifc.req_valid_i = 1'b0;
    ifc.req_a_i = 8'd0;
    ifc.req_b_i = 8'd0;
    mode = 0;
    do_reset("t4_reset_outputs");
    step;
    chk("t4_ready_after_reset", {ifc.fault_o, ifc.req_ready_o}, 2'b01);
    // T5 stale core level
    send(8'd21, 8'd14, 8'd7, 1'b0);
    drain;
    chk("t5_level_left_high", ifc.core_valid_i, 1);
    mode = 2;
    st_v = 1'b1;
    st_g = 8'd0;
    fork
      send(8'd9, 8'd6, 8'd3, 1'b0);
      begin
        wait_pulse(n1);
        for (int i = 0; i < 6; i++) begin
          step;
          chk("t5_no_complete", ifc.rsp_valid_o, 0);
        end
        st_v = 1'b0;
        st_g = 8'd77;
        step;
        step;
        chk("t5_still_waiting", ifc.rsp_valid_o, 0);
        st_v = 1'b1;
        st_g = 8'd3;
        step;
        st_g = 8'd99;
        chk("t5_done", {ifc.rsp_valid_o, ifc.rsp_gcd_o}, {1'b1, 8'd3});
      end
    join
    drain;
    mode = 0;
    // T6 reset while waiting on the core
    fork
      send(8'd128, 8'd64, 8'd64, 1'b0);
      begin
        wait_pulse(n1);
        step;
        chk("t6_in_wait", {ifc.core_valid_o, ifc.rsp_valid_o, ifc.req_ready_o}, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_reset_outputs", all_out, 0);
        reset = 1'b0;
      end
    join
    exp_q.delete();
    send(8'd7, 8'd13, 8'd1, 1'b0);
    drain;
    repeat (3) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
